// File: rtl/mitll_jtl_pkg.sv
// Shared constants for the tick-based JTL array: bias lookup tables and helpers.
// Tables are padded to 16 entries so any 4-bit code indexes them safely.
package mitll_jtl_pkg;
    localparam int BIAS_W   = 4;
    localparam int ERRCNT_W = 16;
    localparam int LUT_W    = 8;

    typedef logic [LUT_W-1:0] lut_t;

    // Entry 0 and 9..15 are invalid codes and read as zero.
    localparam logic [15:0][LUT_W-1:0] DELAY_LUT = {
        {7{8'd0}}, 8'd30, 8'd30, 8'd35, 8'd40, 8'd42, 8'd47, 8'd55, 8'd60, 8'd0
    };
    localparam logic [15:0][LUT_W-1:0] CT_LUT = {
        {7{8'd0}}, 8'd33, 8'd33, 8'd33, 8'd33, 8'd33, 8'd33, 8'd33, 8'd71, 8'd0
    };

    function automatic logic bias_valid(input logic [BIAS_W-1:0] b);
        return (b >= 4'd1) && (b <= 4'd8);
    endfunction

    function automatic lut_t delay_of(input logic [BIAS_W-1:0] b);
        return DELAY_LUT[b];
    endfunction

    function automatic lut_t ct_of(input logic [BIAS_W-1:0] b);
        return CT_LUT[b];
    endfunction
endpackage

// File: rtl/mitll_jtl_chan.sv
// One JTL channel: stamp FIFO of in-flight pulses, critical-timing timer,
// sticky error flag and the toggle-encoded output.
module mitll_jtl_chan
    import mitll_jtl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               edg,
    input  logic [STAMP_W-1:0] tick,
    input  logic [STAMP_W-1:0] dly_m1,
    input  lut_t               ct_m1,
    output logic               out,
    output logic               err,
    output logic               viol
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][STAMP_W-1:0] mem_q, mem_d;
    logic [PTR_W:0]                wr_q, wr_d, rd_q, rd_d;
    lut_t                          ct_q, ct_d;
    logic                          err_q, err_d, out_q, out_d;
    logic                          empty, full, pop, push;
    logic [STAMP_W-1:0]            age;
    lut_t                          ct_dec;

    always_comb begin
        empty  = (wr_q == rd_q);
        full   = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
        // Modular age; the stamp counter is allowed to wrap between push and pop.
        age    = tick - mem_q[rd_q[PTR_W-1:0]];
        pop    = !empty && !err_q && (age == dly_m1);
        // A full FIFO that drains this tick still has room for the new stamp.
        viol   = edg && !err_q && ((ct_q != '0) || (full && !pop));
        push   = edg && !err_q && !viol;
        ct_dec = (ct_q != '0) ? ct_q - 8'd1 : ct_q;

        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        ct_d  = ct_q;
        err_d = err_q;
        out_d = out_q;

        if (flush) begin
            rd_d  = wr_q;
            ct_d  = '0;
            err_d = 1'b0;
        end else if (err_q) begin
            rd_d = wr_q;
            ct_d = ct_dec;
        end else begin
            ct_d = ct_dec;
            if (pop) begin
                rd_d  = rd_q + 1'b1;
                out_d = ~out_q;
            end
            if (push) begin
                mem_d[wr_q[PTR_W-1:0]] = tick;
                wr_d = wr_q + 1'b1;
                ct_d = ct_m1;
            end
            if (viol) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            ct_q  <= '0;
            err_q <= 1'b0;
            out_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ct_q  <= ct_d;
            err_q <= err_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;
    assign err = err_q;
endmodule

// File: rtl/mitll_jtl_array_tick.sv
// Multi-channel tick-based JTL delay model: shared tick counter, warmup,
// bias latch and saturating violation counter around NCH channel instances.
module mitll_jtl_array_tick
    import mitll_jtl_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 12,
    parameter int WARMUP  = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BIAS_W-1:0]   bias_code,
    input  logic                clr_err,
    input  logic [NCH-1:0]      in,
    output logic [NCH-1:0]      out,
    output logic [NCH-1:0]      err,
    output logic                bias_bad,
    output logic [ERRCNT_W-1:0] err_count
);
    localparam int WARM_W = $clog2(WARMUP + 2);

    logic [STAMP_W-1:0]  tick_q, tick_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [BIAS_W-1:0]   bias_q;
    logic [NCH-1:0]      in_q, in_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    logic                bias_ok;
    logic [NCH-1:0]      acc, out_ch, err_ch, viol_ch;
    logic [STAMP_W-1:0]  dly_m1;
    lut_t                ct_m1;
    logic [ERRCNT_W:0]   nviol, sum;

    always_comb begin
        bias_ok = bias_valid(bias_q);
        dly_m1  = STAMP_W'(delay_of(bias_q) - 8'd1);
        ct_m1   = ct_of(bias_q) - 8'd1;
        tick_d  = tick_q + 1'b1;
        warm_d  = (warm_q != '0) ? warm_q - 1'b1 : warm_q;
        in_d    = in;
        // Edges are dropped during warmup, on a clear tick, and under a bad bias.
        acc     = (in ^ in_q) & {NCH{(warm_q == '0) && !clr_err && bias_ok}};

        nviol = '0;
        for (int i = 0; i < NCH; i++) nviol = nviol + {{ERRCNT_W{1'b0}}, viol_ch[i]};
        sum         = {1'b0, err_count_q} + nviol;
        err_count_d = sum[ERRCNT_W] ? '1 : sum[ERRCNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q      <= '0;
            warm_q      <= WARM_W'(WARMUP);
            bias_q      <= bias_code;
            in_q        <= in;
            err_count_q <= '0;
        end else begin
            tick_q      <= tick_d;
            warm_q      <= warm_d;
            in_q        <= in_d;
            err_count_q <= err_count_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mitll_jtl_chan #(
            .DEPTH   (DEPTH),
            .STAMP_W (STAMP_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (clr_err),
            .edg     (acc[i]),
            .tick    (tick_q),
            .dly_m1  (dly_m1),
            .ct_m1   (ct_m1),
            .out     (out_ch[i]),
            .err     (err_ch[i]),
            .viol    (viol_ch[i])
        );
    end

    assign out       = out_ch;
    assign err       = bias_ok ? err_ch : '1;
    assign bias_bad  = !bias_ok;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_mitll_jtl_array_tick.sv
// Directed bench for mitll_jtl_array_tick: expected output toggle times are
// queued when an input edge is driven and retired when the output toggles.
module tb_mitll_jtl_array_tick;
    localparam int NCH = 4;

    logic           clk;
    logic           rst_n;
    logic [3:0]     bias_code;
    logic           clr_err;
    logic [NCH-1:0] in_s;
    logic [NCH-1:0] out;
    logic [NCH-1:0] err;
    logic           bias_bad;
    logic [15:0]    err_count;

    mitll_jtl_array_tick #(
        .NCH(NCH), .DEPTH(4), .STAMP_W(12), .WARMUP(40)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bias_code (bias_code),
        .clr_err   (clr_err),
        .in        (in_s),
        .out       (out),
        .err       (err),
        .bias_bad  (bias_bad),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick index: value n is seen between edge n-1 and edge n after reset release.
    int tk;
    always @(posedge clk) begin
        if (!rst_n) tk <= 0;
        else        tk <= tk + 1;
    end

    typedef struct { int ch; int t; } exp_t;
    exp_t sb[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [NCH-1:0] prev_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (tick %0d)", tag, obs, exp_v, tk);
        end
    endtask

    task automatic monitor();
        for (int c = 0; c < NCH; c++) begin
            if (out[c] !== prev_out[c]) begin
                int idx = -1;
                for (int k = 0; k < sb.size(); k++)
                    if (idx < 0 && sb[k].ch == c) idx = k;
                chk($sformatf("toggle_time_ch%0d", c), tk, (idx < 0) ? -1 : sb[idx].t);
                if (idx >= 0) sb.delete(idx);
            end
        end
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].t < tk) begin
                chk($sformatf("missed_toggle_ch%0d", sb[k].ch), tk - 1, sb[k].t);
                sb.delete(k);
            end
        end
        prev_out = out;
    endtask

    task automatic run_to(input int n);
        while (tk < n) begin
            @(negedge clk);
            monitor();
        end
    endtask

    task automatic tog(input int ch);
        in_s[ch] = ~in_s[ch];
    endtask

    task automatic expect_at(input int ch, input int t);
        sb.push_back('{ch, t});
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        run_to(tk + 1);
        clr_err = 1'b0;
    endtask

    task automatic do_reset(input logic [3:0] code);
        @(negedge clk);
        rst_n     = 1'b0;
        bias_code = code;
        clr_err   = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        rst_n    = 1'b1;
        prev_out = out;
        chk("rst_out", out, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_bias_bad", bias_bad, (code >= 1 && code <= 8) ? 0 : 1);
        chk("rst_err", err, (code >= 1 && code <= 8) ? 4'h0 : 4'hF);
    endtask

    initial begin
        rst_n = 1'b0; bias_code = 4'd5; clr_err = 1'b0; in_s = '0; prev_out = '0;

        // Code 5: D=40, CT=33.
        do_reset(4'd5);
        bias_code = 4'd0;                          // ignored outside reset
        run_to(10);  tog(0);                       // warmup: discarded
        run_to(39);  tog(2);                       // last warmup tick: discarded
        run_to(40);  tog(2); expect_at(2, 80);     // first accepted tick
        run_to(100); in_s = ~in_s; expect_at(0, 140);
        run_to(110); tog(2); tog(3);               // two violations in one tick
        run_to(120); tog(1);                       // third violation
        run_to(121);
        chk("viol_err", err, 4'b1110);
        chk("viol_count", err_count, 3);
        chk("bias_still_ok", bias_bad, 0);
        run_to(150); tog(1);                       // ignored while err set
        run_to(151);
        chk("err_edge_ignored", err_count, 3);
        run_to(200);
        chk("frozen_out", out, 4'b0101);
        pulse_clr();
        chk("clr_err_flags", err, 4'b0000);
        chk("clr_count_held", err_count, 3);
        chk("clr_out_held", out, 4'b0101);
        run_to(250); tog(0);                       // flushed by the clear below
        run_to(260); pulse_clr();
        run_to(300); tog(0); expect_at(0, 340);
        run_to(400); tog(0); tog(2); expect_at(0, 440);
        run_to(432); tog(2);                       // gap 32 < CT
        run_to(433); tog(0); expect_at(0, 473);    // gap 33 == CT: legal
        run_to(434);
        chk("ct_boundary_err", err, 4'b0100);
        chk("ct_boundary_count", err_count, 4);
        run_to(480);

        // Code 8: D=30, five pulses through a depth-4 FIFO.
        do_reset(4'd8);
        for (int k = 0; k < 5; k++) begin
            run_to(100 + 35 * k); tog(0); expect_at(0, 130 + 35 * k);
        end
        run_to(280);
        chk("train_err", err, 0);
        chk("train_count", err_count, 0);

        // Code 1: D=60, CT=71.
        do_reset(4'd1);
        run_to(100); tog(0); tog(1); expect_at(0, 160); expect_at(1, 160);
        run_to(160); tog(1);
        run_to(161);
        chk("b1_err", err, 4'b0010);
        chk("b1_count", err_count, 1);
        run_to(171); tog(0); expect_at(0, 231);    // gap 71 == CT
        run_to(240);
        chk("b1_err_after", err, 4'b0010);

        // Invalid bias codes.
        do_reset(4'd0);
        run_to(100); in_s = ~in_s;
        run_to(200);
        chk("bad_out", out, 0);
        chk("bad_count", err_count, 0);
        chk("bad_err", err, 4'hF);
        do_reset(4'd9);
        run_to(5);
        do_reset(4'd4);
        run_to(100); tog(3); expect_at(3, 142);
        run_to(160);
        chk("recover_err", err, 0);

        // Code 7 (D=30): pulse straddles the 12-bit tick wrap, then reset mid-flight.
        do_reset(4'd7);
        run_to(4090); tog(0); expect_at(0, 4120);
        run_to(4130);
        chk("wrap_out", out, 4'b0001);
        run_to(4150); tog(0);
        run_to(4160);
        do_reset(4'd7);
        run_to(100);
        chk("midrst_out", out, 0);
        chk("final_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
